fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch stage: PC register, PC+4 increment, synchronous instruction-memory
//  request port and a DEPTH-entry prefetch queue in front of decode. Replaces the single-register
//  fetch path with ready/valid handshake to decode and a redirect (branch/jump) flush. Sits between
//  the PC/branch resolution logic and the IF/ID boundary.
// PARAMETERS
//  ADDR_W   32          PC / memory address width
//  INST_W   32          instruction width
//  DEPTH    4           prefetch queue entries; power of two, >= 2
//  RESET_PC 32'h0       fetch address loaded at reset
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       synchronous, active-low reset
//  redirect     in   1       flush queue and restart fetch at redirect_pc
//  redirect_pc  in   ADDR_W  new fetch address; bits [1:0] forced to 0
//  imem_req     out  1       memory read request this cycle
//  imem_addr    out  ADDR_W  read address (= fetch_pc)
//  imem_rdata   in   INST_W  read data, valid exactly 1 cycle after imem_req
//  if_valid     out  1       queue head valid
//  if_ready     in   1       decode accepts head this cycle
//  if_inst      out  INST_W  head instruction
//  if_pc        out  ADDR_W  address of head instruction
//  if_pc4       out  ADDR_W  if_pc + 4 (mod 2^ADDR_W)
// BEHAVIOUR
//  Reset (reset==0 at edge): fetch_pc<=RESET_PC, queue empty, inflight<=0. While reset low:
//   imem_req=0, if_valid=0. if_inst/if_pc/if_pc4 read 0 when queue empty.
//  State: fetch_pc, inflight (1b: response arrives this cycle), queue RAM + rd/wr ptrs + count.
//  pop  = if_valid & if_ready. push = inflight & ~redirect; pushes {imem_rdata, pc of request}.
//  Issue: imem_req = reset & ~redirect & (count + inflight - pop < DEPTH); imem_req is
//   combinational on if_ready/redirect. imem_addr = fetch_pc (registered).
//  On issue: fetch_pc <= fetch_pc + 4 (wraps mod 2^ADDR_W); inflight <= 1, else inflight <= 0.
//  Latency: request in cycle t -> data pushed at end of t+1 -> if_valid in t+2.
//  Throughput: one instruction/cycle sustained when if_ready held high, any DEPTH >= 2.
//  Full: no push lost; issue gating guarantees count never exceeds DEPTH. Push+pop same cycle
//   at full or empty: count unchanged, order preserved.
//  Empty: if_valid=0; pop ignored.
//  Redirect (priority over all): at edge, queue cleared (count=0, ptrs reset), inflight<=0,
//   response arriving this cycle discarded, fetch_pc <= {redirect_pc[ADDR_W-1:2],2'b00}.
//   No request issued in the redirect cycle; first request at redirect_pc in t+1, if_valid in t+3.
//   A pop in the redirect cycle is a completed transfer (decode squashes it).
//  Reset mid-operation: same as reset; all queued and in-flight data discarded.
//  Pointers wrap modulo DEPTH; ordering strictly FIFO.
// TESTING
//  1. RESET_PC=0x00400000, imem_rdata=addr^0xA5A5A5A5, if_ready=1 -> if_valid from cycle 2,
//     if_pc 0x00400000,0x00400004,0x00400008... one per cycle, if_pc4=if_pc+4.
//  2. DEPTH=4, if_ready=0 for 10 cycles -> count reaches 4, imem_req low, no drop/dup;
//     if_ready=1 -> 4 queued then stream resumes in order without gaps.
//  3. 3 entries queued + 1 in flight, redirect=1, redirect_pc=0x00000103 -> if_valid=0 in t+1,t+2;
//     t+3 if_pc=0x00000100; stale data never appears.
//  4. redirect_pc=0xFFFFFFFC -> if_pc 0xFFFFFFFC then 0x00000000; first if_pc4=0x00000000.
//  5. Full queue, reset=0 one cycle -> next cycle if_valid=0, imem_req=0; after release fetch
//     restarts at RESET_PC.
//  6. Full queue, if_ready=1 and redirect=1 same cycle -> head consumed once, queue empty after,
//     imem_req=0 that cycle, next request at redirect_pc.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch stage with PC register, synchronous
// instruction-memory request port and a DEPTH-entry prefetch queue that
// feeds decode through a valid/ready handshake. A redirect flushes all
// queued and in-flight fetches and restarts fetch at the new address.
//
// Handshake: the queue offers its head on if_valid/if_inst/if_pc/if_pc4;
// a transfer completes in any cycle where if_valid and if_ready are both
// high (including a redirect cycle, where decode is expected to squash it).
// if_valid never depends on if_ready; if_ready may depend on if_valid.
module fetch_queue_unit #(
    parameter int               ADDR_W   = 32,
    parameter int               INST_W   = 32,
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;     // address of the request whose data arrives next cycle
    logic              inflight;   // a memory response arrives this cycle
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              pop;
    logic              push;
    logic [CNT_W:0]    occupancy;  // slots committed after this cycle's pop

    // Head presentation, handshake and issue gating.
    // Issue counts the in-flight response as occupied so a push can never overflow.
    always_comb begin
        if_valid  = reset & (count != '0);
        pop       = if_valid & if_ready;
        push      = inflight & ~redirect;
        occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
        imem_req  = reset & ~redirect & (occupancy < DEPTH_V);
        imem_addr = fetch_pc;
        if_inst   = '0;
        if_pc     = '0;
        if_pc4    = '0;
        if (if_valid) begin
            if_inst = inst_mem[rd_ptr];
            if_pc   = pc_mem[rd_ptr];
            if_pc4  = pc_mem[rd_ptr] + ADDR_W'(4);
        end
    end

    // PC, in-flight tracking and queue pointers; reset beats redirect beats normal flow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~ADDR_W'(3);
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (imem_req) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
                req_pc   <= fetch_pc;
            end
            inflight <= imem_req;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: capture the arriving instruction with the address it was fetched from.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            inst_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed sequences covering reset, streaming,
// back-pressure to full, redirects (including address wrap and a redirect
// coinciding with a pop) and reset while the queue is full.
module tb_fetch_queue_unit;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  fetch_queue_unit #(
    .ADDR_W  (32),
    .INST_W  (32),
    .DEPTH   (4),
    .RESET_PC(32'h0040_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .if_pc4     (if_pc4)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial imem_rdata = '0;
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ 32'hA5A5_A5A5;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // one clock: score any completed transfer at negedge, return just after posedge
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    if (if_valid && if_ready) begin
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pop_pc", if_pc, e);
        check("pop_pc4", if_pc4, e + 32'd4);
        check("pop_inst", if_inst, e ^ 32'hA5A5_A5A5);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    repeat (3) step();
    #1;
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_inst",  if_inst, 32'd0);
    check("rst_pc",    if_pc,   32'd0);
    check("rst_pc4",   if_pc4,  32'd0);

    // 1: stream from RESET_PC
    sb_seq(32'h0040_0000, 64);
    reset = 1'b1; if_ready = 1'b1; #1;
    check("t1_c0_req",   32'(imem_req), 32'd1);
    check("t1_c0_addr",  imem_addr, 32'h0040_0000);
    check("t1_c0_valid", 32'(if_valid), 32'd0);
    step(); #1;
    check("t1_c1_valid", 32'(if_valid), 32'd0);
    check("t1_c1_addr",  imem_addr, 32'h0040_0004);
    step(); #1;
    check("t1_c2_valid", 32'(if_valid), 32'd1);
    check("t1_c2_pc",    if_pc,   32'h0040_0000);
    check("t1_c2_inst",  if_inst, 32'hA5E5_A5A5);
    check("t1_c2_pc4",   if_pc4,  32'h0040_0004);
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      check("t1_stream_valid", 32'(if_valid), 32'd1);
    end

    // 2: back-pressure until full, then resume without gaps
    if_ready = 1'b0;
    repeat (10) step();
    #1;
    check("t2_full_req",   32'(imem_req), 32'd0);
    check("t2_full_valid", 32'(if_valid), 32'd1);
    check("t2_head",       if_pc, 32'h0040_0018);
    check("t2_fetch_pc",   imem_addr, 32'h0040_0028);
    if_ready = 1'b1; #1;
    check("t2_resume_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      check("t2_stream_valid", 32'(if_valid), 32'd1);
    end

    // 3: redirect with 3 queued + 1 in flight
    if_ready = 1'b0;
    repeat (10) step();
    if_ready = 1'b1;
    step();
    if_ready = 1'b0; #1;
    check("t3_pre_req", 32'(imem_req), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
    check("t3_redir_req", 32'(imem_req), 32'd0);
    step();
    redirect = 1'b0;
    exp_q.delete();
    sb_seq(32'h0000_0100, 16);
    #1;
    check("t3_t1_valid", 32'(if_valid), 32'd0);
    check("t3_t1_req",   32'(imem_req), 32'd1);
    check("t3_t1_addr",  imem_addr, 32'h0000_0100);
    if_ready = 1'b1;
    step(); #1;
    check("t3_t2_valid", 32'(if_valid), 32'd0);
    step(); #1;
    check("t3_t3_valid", 32'(if_valid), 32'd1);
    check("t3_t3_pc",    if_pc, 32'h0000_0100);
    repeat (3) step();

    // 4: redirect to top of address space, wrap to zero
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    check("t4_redir_req", 32'(imem_req), 32'd0);
    step();
    redirect = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFFC);
    sb_seq(32'h0000_0000, 8);
    #1;
    check("t4_t1_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    step(); #1;
    check("t4_t3_valid", 32'(if_valid), 32'd1);
    check("t4_t3_pc",    if_pc,  32'hFFFF_FFFC);
    check("t4_t3_pc4",   if_pc4, 32'h0000_0000);
    step(); #1;
    check("t4_wrap_pc",  if_pc,  32'h0000_0000);
    repeat (3) step();

    // 6: full queue, pop and redirect in the same cycle
    if_ready = 1'b0;
    repeat (10) step();
    #1;
    check("t6_full_req", 32'(imem_req), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_2000; if_ready = 1'b1; #1;
    check("t6_redir_req",   32'(imem_req), 32'd0);
    check("t6_redir_valid", 32'(if_valid), 32'd1);
    step();
    redirect = 1'b0; if_ready = 1'b0;
    exp_q.delete();
    sb_seq(32'h0000_2000, 16);
    #1;
    check("t6_empty_valid", 32'(if_valid), 32'd0);
    check("t6_t1_req",      32'(imem_req), 32'd1);
    check("t6_t1_addr",     imem_addr, 32'h0000_2000);
    step(); #1;
    check("t6_t2_valid", 32'(if_valid), 32'd0);
    step(); #1;
    check("t6_t3_valid", 32'(if_valid), 32'd1);
    check("t6_t3_pc",    if_pc, 32'h0000_2000);
    repeat (10) step();
    #1;
    check("t6_refill_req",  32'(imem_req), 32'd0);
    check("t6_refill_head", if_pc, 32'h0000_2000);

    // 5: reset while full
    reset = 1'b0; #1;
    check("t5_rst_req",   32'(imem_req), 32'd0);
    check("t5_rst_valid", 32'(if_valid), 32'd0);
    step();
    reset = 1'b1;
    exp_q.delete();
    sb_seq(32'h0040_0000, 16);
    #1;
    check("t5_post_valid", 32'(if_valid), 32'd0);
    check("t5_post_req",   32'(imem_req), 32'd1);
    check("t5_post_addr",  imem_addr, 32'h0040_0000);
    if_ready = 1'b1;
    step();
    step(); #1;
    check("t5_restart_valid", 32'(if_valid), 32'd1);
    check("t5_restart_pc",    if_pc, 32'h0040_0000);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
